mux_fifo_src_gen: RTL

Upstream feeder for `mux_fifo_core`. It accepts a transfer descriptor, issues word-aligned memory reads, and turns the returned words into the per-beat `src_*` stream that `mux_fifo_core` packs. For each beat it generates:
- `src_bgin`, `src_unit_num`, `src_offset` and `src_done`, per beat;
- `src_initial_offset`, `src_last` and `src_user_info`, held constant for the whole command.

---
 rtl/mux_fifo_src_gen.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/mux_fifo_src_gen.sv
// mux_fifo_src_gen
//   Upstream feeder for mux_fifo_core. It takes one transfer descriptor at a
//   time, issues word-aligned reads, and turns each returned word into one
//   src_* beat. Each beat carries the valid unit count, the first valid unit
//   and the begin/done flags. It also carries the per-command fields
//   initial_offset, last and user_info.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   synchronous abort; late read data is then drained
//   cmd_*                   descriptor handshake (src/dst address, length,
//                           last flag, sideband)
//   rd_req_*                word-aligned read request channel
//   rd_data_*               read return channel, in request order
//   src_*                   per-beat output stream toward mux_fifo_core
//   busy                    high while a command is running
module mux_fifo_src_gen #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned DATA_UNIT       = 8,
    parameter int unsigned USER_INFO_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned LEN_WIDTH       = 16,
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned OFST_WIDTH     = $clog2(DATA_WIDTH / DATA_UNIT)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,

    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [ADDR_WIDTH-1:0]      cmd_src_addr,
    input  logic [ADDR_WIDTH-1:0]      cmd_dst_addr,
    input  logic [LEN_WIDTH-1:0]       cmd_len,
    input  logic                       cmd_last,
    input  logic [USER_INFO_WIDTH-1:0] cmd_user_info,

    output logic                       rd_req_valid,
    input  logic                       rd_req_ready,
    output logic [ADDR_WIDTH-1:0]      rd_req_addr,

    input  logic                       rd_data_valid,
    output logic                       rd_data_ready,
    input  logic [DATA_WIDTH-1:0]      rd_data,

    output logic                       src_valid,
    input  logic                       src_ready,
    output logic [DATA_WIDTH-1:0]      src_data,
    output logic                       src_bgin,
    output logic                       src_done,
    output logic                       src_last,
    output logic [OFST_WIDTH:0]        src_unit_num,
    output logic [OFST_WIDTH-1:0]      src_offset,
    output logic [OFST_WIDTH-1:0]      src_initial_offset,
    output logic [USER_INFO_WIDTH-1:0] src_user_info,
    output logic                       busy
);

    localparam int unsigned N  = DATA_WIDTH / DATA_UNIT;
    localparam int unsigned UW = OFST_WIDTH + 1;
    localparam int unsigned CW = LEN_WIDTH + 1;
    localparam int unsigned SW = LEN_WIDTH + 2;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [OW-1:0]         MAX_OUT   = OW'(MAX_OUTSTANDING);
    localparam logic [UW-1:0]         N_UNITS   = UW'(N);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(N);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                     state_q;
    logic [OFST_WIDTH-1:0]      lo_q;
    logic [OFST_WIDTH-1:0]      init_off_q;
    logic [LEN_WIDTH-1:0]       rem_q;
    logic [CW-1:0]              req_left_q;
    logic [ADDR_WIDTH-1:0]      req_addr_q;
    logic [OW-1:0]              outstanding_q;
    logic [OW-1:0]              outstanding_d;
    logic                       discard_q;
    logic                       first_q;
    logic                       last_q;
    logic [USER_INFO_WIDTH-1:0] user_q;

    logic                       src_valid_q;
    logic                       src_bgin_q;
    logic                       src_done_q;
    logic [UW-1:0]              src_unit_num_q;
    logic [OFST_WIDTH-1:0]      src_offset_q;
    logic [DATA_WIDTH-1:0]      src_data_q;

    logic                       cmd_hs;
    logic                       req_hs;
    logic                       data_hs;
    logic                       data_load;
    logic                       src_hs;

    logic [OFST_WIDTH-1:0]      cmd_lo;
    logic [SW-1:0]              cmd_sum;
    logic [CW-1:0]              cmd_beats;

    logic [OFST_WIDTH-1:0]      beat_off;
    logic [UW-1:0]              beat_avail;
    logic [UW-1:0]              beat_units;
    logic [LEN_WIDTH-1:0]       beat_rem;
    logic                       beat_done;

    // Only the in-word offset of the destination address matters here.
    logic                       unused_dst_hi;
    assign unused_dst_hi = ^cmd_dst_addr[ADDR_WIDTH-1:OFST_WIDTH];

    assign cmd_ready     = (state_q == IDLE) && (outstanding_q == '0);
    assign busy          = (state_q == RUN);
    assign rd_req_valid  = (state_q == RUN) && (req_left_q != '0) && (outstanding_q < MAX_OUT);
    assign rd_req_addr   = req_addr_q;
    assign rd_data_ready = ((state_q == RUN) && (!src_valid_q || src_ready)) || discard_q;

    assign src_valid          = src_valid_q;
    assign src_data           = src_data_q;
    assign src_bgin           = src_bgin_q;
    assign src_done           = src_done_q;
    assign src_last           = last_q;
    assign src_unit_num       = src_unit_num_q;
    assign src_offset         = src_offset_q;
    assign src_initial_offset = init_off_q;
    assign src_user_info      = user_q;

    always_comb begin
        cmd_hs    = cmd_valid && cmd_ready;
        req_hs    = rd_req_valid && rd_req_ready;
        data_hs   = rd_data_valid && rd_data_ready;
        // While draining after a flush, returned words are consumed but dropped.
        data_load = data_hs && (state_q == RUN) && !discard_q;
        src_hs    = src_valid_q && src_ready;

        cmd_lo    = cmd_src_addr[OFST_WIDTH-1:0];
        cmd_sum   = SW'(cmd_lo) + SW'(cmd_len) + SW'(N - 1);
        cmd_beats = CW'(cmd_sum >> OFST_WIDTH);

        beat_off   = first_q ? lo_q : '0;
        beat_avail = N_UNITS - UW'(beat_off);
        if (rem_q < LEN_WIDTH'(beat_avail)) begin
            beat_units = rem_q[UW-1:0];
        end else begin
            beat_units = beat_avail;
        end
        beat_rem  = rem_q - LEN_WIDTH'(beat_units);
        beat_done = (beat_rem == '0);

        outstanding_d = outstanding_q;
        if (req_hs && !data_hs) begin
            outstanding_d = outstanding_q + OW'(1);
        end else if (!req_hs && data_hs) begin
            outstanding_d = outstanding_q - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            lo_q           <= '0;
            init_off_q     <= '0;
            rem_q          <= '0;
            req_left_q     <= '0;
            req_addr_q     <= '0;
            outstanding_q  <= '0;
            discard_q      <= 1'b0;
            first_q        <= 1'b0;
            last_q         <= 1'b0;
            user_q         <= '0;
            src_valid_q    <= 1'b0;
            src_bgin_q     <= 1'b0;
            src_done_q     <= 1'b0;
            src_unit_num_q <= '0;
            src_offset_q   <= '0;
            src_data_q     <= '0;
        end else begin
            // The counter follows the bus even during flush, so requests
            // taken in the flush cycle are still drained afterwards.
            outstanding_q <= outstanding_d;

            if (flush) begin
                state_q     <= IDLE;
                src_valid_q <= 1'b0;
                req_left_q  <= '0;
                discard_q   <= (outstanding_d != '0);
            end else begin
                if (discard_q && (outstanding_d == '0)) begin
                    discard_q <= 1'b0;
                end

                case (state_q)
                    IDLE: begin
                        if (cmd_hs) begin
                            lo_q       <= cmd_lo;
                            init_off_q <= cmd_dst_addr[OFST_WIDTH-1:0];
                            rem_q      <= cmd_len;
                            req_addr_q <= {cmd_src_addr[ADDR_WIDTH-1:OFST_WIDTH], {OFST_WIDTH{1'b0}}};
                            last_q     <= cmd_last;
                            user_q     <= cmd_user_info;
                            first_q    <= 1'b1;
                            if (cmd_len != '0) begin
                                req_left_q <= cmd_beats;
                                state_q    <= RUN;
                            end
                        end
                    end

                    RUN: begin
                        if (req_hs) begin
                            req_addr_q <= req_addr_q + ADDR_STEP;
                            req_left_q <= req_left_q - CW'(1);
                        end
                        if (data_load) begin
                            src_valid_q    <= 1'b1;
                            src_data_q     <= rd_data;
                            src_bgin_q     <= first_q;
                            src_offset_q   <= beat_off;
                            src_unit_num_q <= beat_units;
                            src_done_q     <= beat_done;
                            rem_q          <= beat_rem;
                            first_q        <= 1'b0;
                        end else if (src_hs) begin
                            src_valid_q <= 1'b0;
                            if (src_done_q) begin
                                state_q <= IDLE;
                            end
                        end
                    end

                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
